// File: rtl/mdu_pipe_if.sv
// Bus between the D-stage/pipeline control and the multiply/divide unit.
// The pipeline side uses the master modport, the MDU uses the slave modport.
interface mdu_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata, flush,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata, flush,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// An accepted op runs for a fixed number of cycles, then commits to HI/LO;
// flush or reset aborts it without touching HI/LO.
module mdu_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_pipe_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [5:0] MultN = 6'(MULT_CYCLES);
  localparam logic [5:0] DivN  = 6'(DIV_CYCLES);

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               signed_op;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg, div_by_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;

  // Result datapath from the latched operands; divide works on magnitudes so
  // truncation toward zero and the min/-1 overflow case fall out naturally.
  always_comb begin
    signed_op   = ~op_q[0];
    a_ext       = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext       = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod        = a_ext * b_ext;
    a_neg       = signed_op & a_q[WIDTH-1];
    b_neg       = signed_op & b_q[WIDTH-1];
    a_mag       = a_neg ? ('0 - a_q) : a_q;
    b_mag       = b_neg ? ('0 - b_q) : b_q;
    div_by_zero = (b_q == '0);
    q_mag       = div_by_zero ? '0 : (a_mag / b_mag);
    r_mag       = div_by_zero ? '0 : (a_mag % b_mag);
    quo         = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
    // Remainder follows the sign of the dividend.
    rem         = a_neg ? ('0 - r_mag) : r_mag;
  end

  // Next-state: accept, count down, commit, flush and HI/LO moves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        // Flush in the same cycle suppresses acceptance.
        if (bus.start && !bus.flush) begin
          state_d = StRun;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = bus.op[1] ? DivN : MultN;
        end
        // Moves lose to a simultaneous start.
        if (!bus.start) begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == 6'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (!op_q[1]) begin
            {hi_d, lo_d} = prod;
          end else if (!div_by_zero) begin
            lo_d = quo;
            hi_d = rem;
          end
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.stall_req = (state_q == StRun) | bus.start;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// Directed bench for mdu_pipe: default-latency instance plus a
// single-cycle-latency instance sharing clock and reset.
module tb_mdu_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n;

  mdu_pipe_if #(.WIDTH(32)) b0 ();
  mdu_pipe_if #(.WIDTH(32)) b1 ();

  mdu_pipe #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  mdu_pipe #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? b1.busy : b0.busy;
  endfunction

  // Called at a negedge; launches an op, counts busy cycles, ends at the
  // first negedge with busy low and checks the resulting HI/LO.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input string tag);
    int cnt;
    if (sel) begin
      b1.start = 1'b1; b1.op = op; b1.a = a; b1.b = b;
    end else begin
      b0.start = 1'b1; b0.op = op; b0.a = a; b0.b = b;
    end
    @(negedge clk);
    b0.start = 1'b0;
    b1.start = 1'b0;
    cnt = 0;
    while (busy_of(sel) && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_n));
    chk({tag, "_hi"}, sel ? b1.hi : b0.hi, exp_hi);
    chk({tag, "_lo"}, sel ? b1.lo : b0.lo, exp_lo);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    b0.start = 1'b0; b0.op = 2'b00; b0.a = '0; b0.b = '0;
    b0.mthi = 1'b0; b0.mtlo = 1'b0; b0.wdata = '0; b0.flush = 1'b0;
    b1.start = 1'b0; b1.op = 2'b00; b1.a = '0; b1.b = '0;
    b1.mthi = 1'b0; b1.mtlo = 1'b0; b1.wdata = '0; b1.flush = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", b0.busy, 1'b0);
    chk("rst_stall", b0.stall_req, 1'b0);
    chk("rst_hi", b0.hi, 32'h0);
    chk("rst_lo", b0.lo, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Signed multiply and divide basics
    run_op(1'b0, 2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
    run_op(1'b0, 2'b11, 32'd17, 32'd5, 10, 32'd2, 32'd3, "divu_17_5");
    run_op(1'b0, 2'b10, 32'hFFFF_FFEF, 32'd5, 10, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_m17_5");

    // mthi then divide by zero leaves HI/LO untouched
    b0.mthi = 1'b1; b0.wdata = 32'h1234;
    @(negedge clk);
    b0.mthi = 1'b0;
    chk("mthi_hi", b0.hi, 32'h1234);
    chk("mthi_lo_kept", b0.lo, 32'hFFFF_FFFD);
    run_op(1'b0, 2'b10, 32'd99, 32'd0, 10, 32'h1234, 32'hFFFF_FFFD, "div_by_zero");
    run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_ovf");

    // Both moves together
    b0.mthi = 1'b1; b0.mtlo = 1'b1; b0.wdata = 32'h55;
    @(negedge clk);
    b0.mthi = 1'b0; b0.mtlo = 1'b0;
    chk("mt_both_hi", b0.hi, 32'h55);
    chk("mt_both_lo", b0.lo, 32'h55);

    // Flush on the third RUN cycle
    b0.start = 1'b1; b0.op = 2'b01; b0.a = 32'd7; b0.b = 32'd6;
    #1 chk("stall_on_start", b0.stall_req, 1'b1);
    @(negedge clk);
    b0.start = 1'b0;
    chk("stall_while_busy", b0.stall_req, 1'b1);
    repeat (2) @(negedge clk);
    b0.flush = 1'b1;
    @(negedge clk);
    b0.flush = 1'b0;
    chk("flush_busy", b0.busy, 1'b0);
    chk("flush_hi", b0.hi, 32'h55);
    chk("flush_lo", b0.lo, 32'h55);
    run_op(1'b0, 2'b01, 32'd7, 32'd6, 5, 32'h0, 32'd42, "multu_after_flush");

    // Flush on the would-be commit edge
    b0.start = 1'b1; b0.op = 2'b00; b0.a = 32'd2; b0.b = 32'd2;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (4) @(negedge clk);
    b0.flush = 1'b1;
    @(negedge clk);
    b0.flush = 1'b0;
    chk("flush_commit_busy", b0.busy, 1'b0);
    chk("flush_commit_lo", b0.lo, 32'd42);
    chk("flush_commit_hi", b0.hi, 32'h0);

    // Flush and start together in IDLE
    b0.start = 1'b1; b0.flush = 1'b1; b0.op = 2'b01; b0.a = 32'd9; b0.b = 32'd9;
    @(negedge clk);
    b0.start = 1'b0; b0.flush = 1'b0;
    chk("flush_beats_start", b0.busy, 1'b0);

    // start and mtlo while busy are ignored
    b0.start = 1'b1; b0.op = 2'b11; b0.a = 32'd100; b0.b = 32'd7;
    @(negedge clk);
    b0.start = 1'b0;
    @(negedge clk);
    b0.start = 1'b1; b0.op = 2'b00; b0.a = 32'd3; b0.b = 32'd3;
    b0.mtlo = 1'b1; b0.wdata = 32'hDEAD;
    @(negedge clk);
    b0.start = 1'b0; b0.mtlo = 1'b0;
    chk("mtlo_busy_ignored", b0.lo, 32'd42);
    n = 2;
    while (b0.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_ignore_cycles", 64'(n), 64'd10);
    chk("busy_ignore_lo", b0.lo, 32'd14);
    chk("busy_ignore_hi", b0.hi, 32'd2);
    @(negedge clk);
    chk("no_queued_start", b0.busy, 1'b0);

    // Back-to-back ops
    run_op(1'b0, 2'b01, 32'd3, 32'd4, 5, 32'h0, 32'd12, "b2b_first");
    run_op(1'b0, 2'b11, 32'd9, 32'd2, 10, 32'd1, 32'd4, "b2b_second");

    // Reset mid-RUN
    b0.start = 1'b1; b0.op = 2'b11; b0.a = 32'd100; b0.b = 32'd7;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", b0.busy, 1'b0);
    chk("midrst_hi", b0.hi, 32'h0);
    chk("midrst_lo", b0.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_late_commit_busy", b0.busy, 1'b0);
    chk("no_late_commit_hi", b0.hi, 32'h0);
    chk("no_late_commit_lo", b0.lo, 32'h0);
    run_op(1'b0, 2'b01, 32'd2, 32'd3, 5, 32'h0, 32'd6, "post_reset_op");

    // Single-cycle latency instance
    run_op(1'b1, 2'b01, 32'd5, 32'd5, 1, 32'h0, 32'd25, "lat1_multu");
    run_op(1'b1, 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1, 32'h0, 32'd12, "lat1_mult");
    run_op(1'b1, 2'b10, 32'd17, 32'hFFFF_FFFB, 1, 32'd2, 32'hFFFF_FFFD, "lat1_div");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
MDU_PIPE -- requirements
Module: mdu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width in bits.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for multiply ops; legal range is 1..63.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for divide ops; legal range is 1..63.
REQ-004 clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset; low forces the reset state immediately, regardless of clk.
REQ-006 start  input  1: launch the operation selected by op, with operands a and b.
REQ-007 op  input  2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 a, b  input  WIDTH each: operands; a is the multiplicand or dividend, b is the multiplier or divisor.
REQ-009 mthi, mtlo  input  1 each: write wdata to HI or LO respectively.
REQ-010 wdata  input  WIDTH: data for mthi/mtlo.
REQ-011 flush  input  1: abort the operation in flight.
REQ-012 busy  output  1: an operation is in flight.
REQ-013 stall_req  output  1: combinational busy OR start; the D-stage hazard logic uses it to hold md/mf/mt instructions.
REQ-014 hi, lo  output  WIDTH each: architectural HI and LO registers.

Function
REQ-015 Two states: IDLE and RUN; a cycle counter of 6 bits shall track progress in RUN.
REQ-016 IDLE: start=1 at a rising edge shall latch op, a and b and load the counter with N (N = MULT_CYCLES for op 0x, DIV_CYCLES for op 1x); the FSM shall then move to RUN.
REQ-017 RUN: the counter shall decrement every edge; when it reaches 1, that edge shall commit the result to HI/LO and return the FSM to IDLE.
REQ-018 busy=1 exactly for the N cycles following the accepting edge; HI/LO shall update at the N-th edge after acceptance.
REQ-019 MULT and MULTU: {HI,LO} = full 2*WIDTH-bit product, signed or unsigned as selected.
REQ-020 DIV and DIVU: LO = quotient, HI = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-021 Signed overflow (a = most-negative value, b = -1): LO = a, HI = 0.
REQ-022 Divide by zero (b = 0, DIV or DIVU): the op runs its full latency and then leaves HI/LO unchanged.
REQ-023 start while in RUN shall be ignored; the in-flight op continues unaffected.
REQ-024 mthi/mtlo in IDLE with start=0 shall write wdata to HI/LO at the edge; both asserted together shall write both registers.
REQ-025 mthi/mtlo while in RUN, or in the same cycle as start, shall be ignored.
REQ-026 flush in RUN shall return the FSM to IDLE at the next edge with HI/LO unchanged, including on the would-be commit edge; busy shall be 0 the cycle after.
REQ-027 flush and start in the same IDLE cycle: flush wins and the op is not accepted.
REQ-028 Back-to-back: start may be accepted on the first IDLE cycle after a commit, with no bubble beyond that cycle.

Reset
REQ-029 reset low: FSM=IDLE, counter=0, hi=0, lo=0, busy=0, latched operands = 0.
REQ-030 reset asserted during RUN shall abort the op; no commit may occur after reset is released.
REQ-031 After reset is released, the first rising edge shall behave as IDLE.

Verification
REQ-032 MULT a=0xFFFFFFFE (-2), b=3, default params -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 DIVU a=17, b=5 -> busy high 10 cycles, then lo=3, hi=2; DIV a=-17, b=5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFE.
REQ-034 mthi 0x1234 then DIV with b=0 -> 10 busy cycles, then hi=0x1234 and lo unchanged; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-035 MULTU 7*6 started, flush on cycle 3 of RUN -> busy=0 on the next cycle and HI/LO keep their prior values; a second start then completes normally with lo=42.
REQ-036 start while busy, and mtlo while busy -> both ignored, result unchanged; reset pulsed low mid-RUN -> hi=lo=0, busy=0 immediately, and no late commit.
REQ-037 Rebuild with MULT_CYCLES=1, DIV_CYCLES=1 -> busy high for one cycle, and commit on the edge after acceptance.
